// File: rtl/acc_share_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : acc_share_sched                                                |
// | Purpose : Round-robin scheduler time-sharing one accumulator among       |
// |           NUM_REQ requesters. Grants one requester, clears the           |
// |           accumulator, streams LEN words into it, then reports the total |
// |           with a done pulse tagged by requester ID.                      |
// | Ports   : i_CLK, i_RESET (async, active high)                            |
// |           i_REQ / i_REQ_LEN / i_REQ_DATA / i_REQ_VALID  - requesters     |
// |           o_REQ_READY, o_GRANT                           - to requesters |
// |           o_ACC_RESET_N / o_ACC_ENABLE / o_ACC_DATA      - to accum      |
// |           i_ACC_TOTAL                                    - from accum    |
// |           o_DONE / o_ABORT / o_DONE_ID / o_RESULT        - completion    |
// | Option  : define ACC_SHARE_SCHED_TIMEOUT_EN to abort a job after         |
// |           TIMEOUT_CYCLES consecutive beat-less cycles in ACCUM.          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module acc_share_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET,
  input  logic [NUM_REQ-1:0]           i_REQ,
  input  logic [NUM_REQ*LEN_W-1:0]     i_REQ_LEN,
  input  logic [NUM_REQ*DATA_W-1:0]    i_REQ_DATA,
  input  logic [NUM_REQ-1:0]           i_REQ_VALID,
  output logic [NUM_REQ-1:0]           o_REQ_READY,
  output logic [NUM_REQ-1:0]           o_GRANT,
  output logic                         o_ACC_RESET_N,
  output logic                         o_ACC_ENABLE,
  output logic [DATA_W-1:0]            o_ACC_DATA,
  input  logic [DATA_W-1:0]            i_ACC_TOTAL,
  output logic                         o_DONE,
  output logic [$clog2(NUM_REQ)-1:0]   o_DONE_ID,
  output logic [DATA_W-1:0]            o_RESULT,
  output logic                         o_ABORT
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("acc_share_sched: parameter out of range");
  end

  logic [2:0]        state, state_nxt;
  logic [ID_W-1:0]   owner, last_owner, pick;
  logic [ID_W:0]     cand;
  logic              any_req;
  logic [LEN_W-1:0]  job_len, beat_cnt;
  logic              beat, last_beat, in_job, abort_now, timeout;
  logic [LEN_W-1:0]  len_arr  [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign len_arr[g]  = i_REQ_LEN[g*LEN_W +: LEN_W];
    assign data_arr[g] = i_REQ_DATA[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: scan upward from last_owner+1 with wrap. The loop runs
  // from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, last_owner} + (ID_W+1)'(k) + (ID_W+1)'(1);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (i_REQ[cand[ID_W-1:0]]) begin
        pick    = cand[ID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // ready is implied in ACCUM, so a beat is just the owner's valid there.
  assign beat      = (state == S_ACCUM) && i_REQ_VALID[owner];
  assign last_beat = beat && (beat_cnt == job_len - LEN_W'(1));
  assign in_job    = (state == S_CLEAR) || (state == S_ACCUM) || (state == S_DRAIN);
  assign abort_now = in_job && (!i_REQ[owner] || timeout);

`ifdef ACC_SHARE_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      stall_cnt <= '0;
    end else if (state != S_ACCUM || beat) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive beat-less cycle.
  assign timeout = (state == S_ACCUM) && !beat &&
                   (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (abort_now)            state_nxt = S_IDLE;
        else if (job_len == '0)   state_nxt = S_DRAIN;
        else                      state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (abort_now)            state_nxt = S_IDLE;
        else if (last_beat)       state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = abort_now ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs: ready and the accumulator feed pass straight through.
  always_comb begin
    o_REQ_READY  = '0;
    o_ACC_ENABLE = 1'b0;
    o_ACC_DATA   = '0;
    if (state == S_ACCUM) o_REQ_READY[owner] = 1'b1;
    if (beat) begin
      o_ACC_ENABLE = 1'b1;
      o_ACC_DATA   = data_arr[owner];
    end
  end

  assign o_ACC_RESET_N = ~i_RESET && (state != S_CLEAR);

  // Job bookkeeping and registered completion outputs
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      owner      <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
      job_len    <= '0;
      beat_cnt   <= '0;
      o_GRANT    <= '0;
      o_DONE     <= 1'b0;
      o_ABORT    <= 1'b0;
      o_DONE_ID  <= '0;
      o_RESULT   <= '0;
    end else begin
      o_DONE  <= 1'b0;
      o_ABORT <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner   <= pick;
            job_len <= len_arr[pick];
            o_GRANT <= NUM_REQ'(1) << pick;
          end
        end
        S_CLEAR: beat_cnt <= '0;
        S_ACCUM: if (beat) beat_cnt <= beat_cnt + LEN_W'(1);
        S_DONE: begin
          o_RESULT   <= i_ACC_TOTAL;
          o_DONE_ID  <= owner;
          o_DONE     <= 1'b1;
          last_owner <= owner;
          o_GRANT    <= '0;
        end
        default: ;
      endcase
      if (abort_now) begin
        o_ABORT    <= 1'b1;
        o_DONE_ID  <= owner;
        last_owner <= owner;
        o_GRANT    <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_share_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_acc_share_sched                                             |
// | Purpose : Self-checking bench for acc_share_sched with a simple          |
// |           accumulator model and a job-level reference model.             |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_acc_share_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int MAXW    = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req, valid, ready, grant;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      acc_rst_n, acc_en, done, abort;
  logic [DATA_W-1:0]         acc_data, acc_total, result;
  logic [1:0]                done_id;

  always #5 clk = ~clk;

  acc_share_sched #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(64)
  ) dut (
    .i_CLK(clk), .i_RESET(rst),
    .i_REQ(req), .i_REQ_LEN(req_len), .i_REQ_DATA(req_data), .i_REQ_VALID(valid),
    .o_REQ_READY(ready), .o_GRANT(grant),
    .o_ACC_RESET_N(acc_rst_n), .o_ACC_ENABLE(acc_en), .o_ACC_DATA(acc_data),
    .i_ACC_TOTAL(acc_total),
    .o_DONE(done), .o_DONE_ID(done_id), .o_RESULT(result), .o_ABORT(abort)
  );

  // Accumulator instance model
  logic [DATA_W-1:0] acc_q;
  always @(posedge clk) begin
    if (!acc_rst_n)  acc_q <= '0;
    else if (acc_en) acc_q <= acc_q + acc_data;
  end
  assign acc_total = acc_rst_n ? acc_q : '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Client side
  logic [NUM_REQ-1:0] rq    = '0;
  logic [NUM_REQ-1:0] renew = '0;
  int                 c_len [NUM_REQ];
  logic [DATA_W-1:0]  c_w   [NUM_REQ][MAXW];
  int p_valid = 100, p_newjob = 0, p_abort = 0, force_abort_beats = -1;
  bit random_mode = 0;

  // Reference model: job-level view of the scheduler
  bit   busy = 0, pend = 0;
  int   own = 0, jlen = 0, beats = 0, start = 0, done_due = -1, abort_due = -1;
  int   last = NUM_REQ - 1, pend_pick = 0, pend_len = 0;
  logic [DATA_W-1:0] sum = '0, hold_res = '0;

  function automatic int rr_pick(input int lst, input logic [NUM_REQ-1:0] r);
    for (int i = 1; i <= NUM_REQ; i++)
      if (r[(lst + i) % NUM_REQ]) return (lst + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic new_job(input int n, input int len);
    rq[n]    = 1'b1;
    c_len[n] = len;
    for (int i = 0; i < MAXW; i++)
      c_w[n][i] = ($urandom_range(9) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
  endtask

  // One clock cycle: check outputs, advance the model, drive next inputs.
  task automatic step();
    logic [NUM_REQ-1:0] e_grant, e_ready;
    bit e_done, e_abort, hs;
    @(negedge clk);
    cyc++;
    if (pend) begin
      busy = 1; pend = 0; own = pend_pick; jlen = pend_len; beats = 0;
      sum = '0; start = cyc; abort_due = -1;
      done_due = (jlen == 0) ? cyc + 3 : -1;
    end
    e_done  = busy && (cyc == done_due);
    e_abort = busy && (cyc == abort_due);
    e_grant = '0;
    e_ready = '0;
    if (busy && !e_done && !e_abort) e_grant[own] = 1'b1;
    if (busy && !e_abort && cyc != start && beats < jlen) e_ready[own] = 1'b1;
    check_val("grant", grant, e_grant);
    check_val("ready", ready, e_ready);
    check_val("acc_rst_n", acc_rst_n, !(busy && cyc == start));
    check_val("done", done, e_done);
    check_val("abort", abort, e_abort);
    if (e_done) begin
      check_val("result", result, sum);
      check_val("done_id", done_id, own);
      hold_res = sum;
    end else begin
      check_val("result_hold", result, hold_res);
    end
    if (e_abort) check_val("abort_id", done_id, own);
    if (e_done || e_abort) begin
      busy = 0;
      last = own;
    end

    // Client decisions
    for (int n = 0; n < NUM_REQ; n++) begin
      if ((e_done || e_abort) && n == own) begin
        rq[n] = 1'b0;
        if (random_mode ? ($urandom_range(1) == 1) : renew[n])
          new_job(n, random_mode ? $urandom_range(0, 6) : c_len[n]);
      end else if (!rq[n]) begin
        if (p_newjob > $urandom_range(99)) new_job(n, $urandom_range(0, 6));
      end else if (busy && own == n && beats < jlen && abort_due < 0 &&
                   (beats == force_abort_beats || p_abort > $urandom_range(999))) begin
        rq[n] = 1'b0;
        abort_due = cyc + 1;
      end
    end

    // Drive inputs
    for (int n = 0; n < NUM_REQ; n++) begin
      req[n] = rq[n];
      if (busy && own == n && beats < jlen) begin
        valid[n] = rq[n] && ($urandom_range(99) < p_valid);
        req_data[n*DATA_W +: DATA_W] = c_w[n][beats];
      end else begin
        valid[n] = 1'($urandom_range(1));
        req_data[n*DATA_W +: DATA_W] = 32'($urandom);
      end
      req_len[n*LEN_W +: LEN_W] = (busy && own == n) ? 8'($urandom) : 8'(c_len[n]);
    end

    hs = busy && e_ready[own] && valid[own];
    #1;
    check_val("acc_en", acc_en, hs);
    if (hs) begin
      check_val("acc_data", acc_data, c_w[own][beats]);
      sum = sum + c_w[own][beats];
      beats++;
      if (beats == jlen) done_due = cyc + 3;
    end

    if (!busy) begin
      pend_pick = rr_pick(last, req);
      if (pend_pick >= 0) begin
        pend     = 1;
        pend_len = c_len[pend_pick];
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || pend || rq != '0) && k < budget) begin
      step();
      k++;
    end
    check_val("idle_in_budget", k < budget, 1);
  endtask

  task automatic model_reset();
    busy = 0; pend = 0; last = NUM_REQ - 1; hold_res = '0;
    rq = '0; renew = '0; force_abort_beats = -1;
    req = '0; valid = '0; req_len = '0; req_data = '0;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_grant", grant, 0);
    check_val("arst_ready", ready, 0);
    check_val("arst_acc_en", acc_en, 0);
    check_val("arst_acc_data", acc_data, 0);
    check_val("arst_acc_rst_n", acc_rst_n, 0);
    check_val("arst_done", done, 0);
    check_val("arst_abort", abort, 0);
    check_val("arst_done_id", done_id, 0);
    check_val("arst_result", result, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < NUM_REQ; n++) c_len[n] = 0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_grant", grant, 0);
    check_val("rst_acc_rst_n", acc_rst_n, 0);
    check_val("rst_result", result, 0);
    check_val("rst_done", done, 0);
    rst = 1'b0;

    // Single job: 5+7+9
    new_job(0, 3);
    c_w[0][0] = 32'd5; c_w[0][1] = 32'd7; c_w[0][2] = 32'd9;
    wait_idle(40);

    // Two one-word jobs; the clear keeps the sums apart
    new_job(1, 1); c_w[1][0] = 32'hFFFF_FFFF;
    new_job(2, 1); c_w[2][0] = 32'd2;
    wait_idle(40);

    // Requester 0 keeps asking while requester 3 joins
    renew[0] = 1'b1;
    new_job(0, 2);
    repeat (3) step();
    new_job(3, 2);
    repeat (20) step();
    renew[0] = 1'b0;
    wait_idle(40);

    // Zero-length job
    new_job(2, 0);
    wait_idle(40);

    // Owner drops its request after two beats
    force_abort_beats = 2;
    new_job(0, 4);
    wait_idle(40);
    force_abort_beats = -1;

    // Reset in the middle of a job
    new_job(1, 5);
    repeat (4) step();
    mid_reset();
    step();

    // Long stall: no abort without the timeout option
    new_job(3, 3);
    p_valid = 0;
    repeat (100) step();
    p_valid = 100;
    wait_idle(40);

    // Randomized traffic
    random_mode = 1;
    p_newjob = 20; p_valid = 70; p_abort = 15;
    repeat (1200) step();
    mid_reset();
    repeat (1200) step();
    p_newjob = 0; random_mode = 0; renew = '0;
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
